// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// wait-counter width and the access legality check.
package dm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 64;

  // An access is illegal when it is not word aligned or lands past the last word.
  function automatic logic dm_addr_err(input logic [1:0]       byte_off,
                                       input logic [IDX_W-1:0] word_idx,
                                       input logic [IDX_W-1:0] depth);
    logic err;
    err = (byte_off != 2'b00) || (word_idx >= depth);
    return err;
  endfunction

endpackage

// File: rtl/dm_array.sv
// DEPTH x 32 word store: asynchronous clear, one write port and one registered
// read port whose output can be forced to zero.
module dm_array
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AIW   = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [AIW-1:0] waddr_i,
  input  logic [31:0]    wdata_i,
  input  logic           re_i,
  input  logic           rzero_i,
  input  logic [AIW-1:0] raddr_i,
  output logic [31:0]    rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Word storage: cleared on reset so a dropped store can never surface.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q[waddr_i] <= mem_q[waddr_i];
    end
  end

  // Read register: only updated on a response launch, otherwise it holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? 32'd0 : mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Handshaked multi-cycle data-memory slave: one request in flight, programmable
// wait states, commits stores or returns load data, flags illegal accesses.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  localparam int unsigned AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic             ready_q, valid_q, err_q;
  logic             accept_s, commit_s, err_s;
  logic [IDX_W-1:0] word_idx_s;

  assign word_idx_s = IDX_W'(addr_q[AW-1:2]);
  assign err_s      = dm_addr_err(addr_q[1:0], word_idx_s, IDX_W'(DEPTH));

  // Next-state logic for the IDLE -> WAIT -> RESP request handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          accept_s = 1'b1;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = S_WAIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          commit_s = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM, counter and handshake flags; the flags are registered from the
  // next state so req_ready stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_RESP);
    end
  end

  // Request latch and error flag; both hold outside their update cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept_s) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else begin
        write_q <= write_q;
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
      end
      if (commit_s) begin
        err_q <= err_s;
      end else begin
        err_q <= err_q;
      end
    end
  end

  dm_array #(
    .DEPTH (DEPTH),
    .AIW   (AIW)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (commit_s & write_q & ~err_s),
    .waddr_i (addr_q[AIW+1:2]),
    .wdata_i (wdata_q),
    .re_i    (commit_s),
    .rzero_i (write_q | err_s),
    .raddr_i (addr_q[AIW+1:2]),
    .rdata_o (resp_rdata)
  );

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with two wait states and one
// with none, exercising the handshake, storage, error and reset behaviour.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_valid = 1'b0, r1_write = 1'b0, r1_rready = 1'b0;
  logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
  logic        r1_ready, r1_rvalid, r1_err;
  logic [31:0] r1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(64), .WAIT_STATES(2), .AW(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH(64), .WAIT_STATES(0), .AW(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_write(r1_write),
    .req_addr(r1_addr), .req_wdata(r1_wdata),
    .resp_valid(r1_rvalid), .resp_ready(r1_rready),
    .resp_rdata(r1_rdata), .resp_err(r1_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on either instance; lat = edges from acceptance to resp_valid.
  task automatic do_req(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int n;
    if (sel) begin r1_write = w; r1_addr = a; r1_wdata = d; r1_valid = 1'b1; end
    else     begin req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1; end
    n = 0;
    while (!(sel ? r1_ready : req_ready) && n < 20) begin tick(); n++; end
    tick();
    r1_valid = 1'b0; req_valid = 1'b0;
    lat = 0;
    while (!(sel ? r1_rvalid : resp_valid) && lat < 40) begin tick(); lat++; end
    rd = sel ? r1_rdata : resp_rdata;
    er = sel ? r1_err : resp_err;
    if (sel) r1_rready = 1'b1; else resp_ready = 1'b1;
    tick();
    r1_rready = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", req_ready); end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", resp_valid); end
    checks++;
    if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL idle_resp got %h/%b want 00000000/0", resp_rdata, resp_err);
    end
  endtask

  task automatic test_round_trip();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_resp got %h/%b want 00000000/0", rd, er); end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL store_back_idle got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
    end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_10 got %h/%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h13, 32'h12345678, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misaligned_store got %h/%b want 00000000/1", rd, er); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL no_write_10 got %h want deadbeef", rd); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL range_100 got %h/%b want 00000000/1", rd, er); end
    do_req(1'b0, 1'b0, 32'hFC, 32'h0, lat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL last_word got %h/%b want 00000000/0", rd, er); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
  endtask

  task automatic test_backpressure();
    int n; int lat; logic [31:0] rd; logic er;
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin tick(); n++; end
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%b d=%h e=%b want v=1 r=0 d=deadbeef e=0",
                 i, resp_valid, req_ready, resp_rdata, resp_err);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
    end
    do_req(1'b0, 1'b0, 32'h30, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL bp_ignored_req got %h want 00000000", rd); end
  endtask

  task automatic test_reset_mid_wait();
    int n; int lat; logic [31:0] rd; logic er; logic seen;
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_wait_valid got 1 want 0"); end
    do_req(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL mid_wait_load got %h/%b want 00000000/0", rd, er); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er; logic seen;
    do_req(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, lat, rd, er);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL ws0_store_latency got %0d want 1", lat); end
    do_req(1'b1, 1'b0, 32'h24, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hA5A5A5A5 || lat !== 1) begin errors++; $display("FAIL ws0_load got %h lat %0d want a5a5a5a5 lat 1", rd, lat); end
    r1_write = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h11112222; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r1_rvalid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL ws0_reset_valid got 1 want 0"); end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL ws0_dropped_store got %h want 00000000", rd); end
    do_req(1'b1, 1'b0, 32'h24, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL ws0_cleared got %h want 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_misaligned();
    test_range();
    test_backpressure();
    test_reset_mid_wait();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
